booth_mult_unit: RTL and testbench

BOOTH_MULT_UNIT -- requirements
Module: booth_mult_unit

---
 rtl/booth_mult_unit_pkg.sv | 24 ++
 rtl/booth_mult_unit_dp.sv | 78 +++++++
 rtl/booth_mult_unit.sv | 68 ++++++
 tb/tb_booth_mult_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/booth_mult_unit_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_mult_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_SS = 2'b01;
  localparam logic [1:0] MODE_SU = 2'b10;

  // Multiplicand is signed for SS and SU; reserved mode 11 falls back to unsigned.
  function automatic logic mode_a_signed(input logic [1:0] m);
    return (m == MODE_SS) || (m == MODE_SU);
  endfunction

  // Multiplier is signed only for SS.
  function automatic logic mode_b_signed(input logic [1:0] m);
    return (m == MODE_SS);
  endfunction

endpackage

// File: rtl/booth_mult_unit_dp.sv
// Booth datapath: operand capture, radix-4 recoder, adder, shifter, counter, product.
import booth_mult_unit_pkg::*;

module booth_mult_dp #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH/2 + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               tc,
  output logic [2*WIDTH-1:0] product
);

  // E: extended operand width; H: upper accumulator half, 2 guard bits for +-2A sums.
  localparam int E  = WIDTH + 2;
  localparam int H  = E + 2;
  localparam int CW = $clog2(ITER);

  logic [E-1:0]  a_q;
  logic [H-1:0]  hi_q;
  logic [E-1:0]  lo_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;

  logic [H-1:0]   a_h, addend, sum;
  logic [2:0]     win;
  logic [H+E-1:0] pair, shifted;

  assign tc  = (cnt_q == '0);
  assign a_h = {{2{a_q[E-1]}}, a_q};
  assign win = {lo_q[1:0], prev_q};

  // Recode the current window into a digit and form digit*A.
  always_comb begin
    addend = '0;
    case (win)
      3'b001, 3'b010: addend = a_h;
      3'b011:         addend = a_h << 1;
      3'b100:         addend = -(a_h << 1);
      3'b101, 3'b110: addend = -a_h;
      default:        addend = '0;
    endcase
  end

  assign sum     = hi_q + addend;
  assign pair    = {sum, lo_q};
  assign shifted = {{2{sum[H-1]}}, pair[H+E-1:2]};

  // Capture operands on load, advance one Booth step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
    end else if (load) begin
      a_q    <= {{2{mode_a_signed(mode) & multiplicand[WIDTH-1]}}, multiplicand};
      lo_q   <= {{2{mode_b_signed(mode) & multiplier[WIDTH-1]}}, multiplier};
      hi_q   <= '0;
      prev_q <= 1'b0;
      cnt_q  <= CW'(ITER - 1);
    end else if (step) begin
      hi_q   <= shifted[H+E-1:E];
      lo_q   <= shifted[E-1:0];
      prev_q <= lo_q[1];
      if (tc) product <= shifted[2*WIDTH-1:0];
      else    cnt_q   <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Radix-4 Booth multiplier: handshake FSM around the Booth datapath.
import booth_mult_unit_pkg::*;

module booth_mult_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH/2 + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               res_valid,
  input  logic               res_ready
);

  state_t state;
  logic   load, step, tc;

  assign load = (state == IDLE) && valid;
  assign step = (state == CALC);

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          state    <= CALC;
          in_ready <= 1'b0;
        end
        CALC: if (tc) begin
          state     <= DONE;
          res_valid <= 1'b1;
        end
        DONE: if (res_ready) begin
          state     <= IDLE;
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  booth_mult_dp #(.WIDTH(WIDTH), .ITER(ITER)) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .mode         (mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .tc           (tc),
    .product      (product)
  );

endmodule

// File: tb/tb_booth_mult_unit.sv
// Randomized + directed bench for booth_mult_unit against an arithmetic model.
module tb_booth_mult_unit;

  localparam int W    = 32;
  localparam int ITER = W/2 + 1;

  logic          clk = 1'b0;
  logic          rst_n, valid, res_ready, in_ready, res_valid;
  logic [1:0]    mode;
  logic [W-1:0]  multiplicand, multiplier;
  logic [2*W-1:0] product;

  int n_chk = 0;
  int n_err = 0;

  booth_mult_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (valid),
    .in_ready     (in_ready),
    .mode         (mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .res_valid    (res_valid),
    .res_ready    (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits per mode and multiply modulo 2^64.
  function automatic logic [63:0] ref_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    logic sa, sb;
    sa = (m == 2'b01) || (m == 2'b10);
    sb = (m == 2'b01);
    ax = sa ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sb ? {{32{b[31]}}, b} : {32'd0, b};
    return ax * bx;
  endfunction

  // Issue one operation from IDLE; returns product and edges from accept to res_valid.
  task automatic start_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] p, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    mode = m; multiplicand = a; multiplier = b; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    mode = $urandom; multiplicand = $urandom; multiplier = $urandom;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!res_valid) chk("res_valid_timeout", 64'(res_valid), 64'd1);
    p = product;
  endtask

  task automatic finish_op();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] p, hold;
    int lat;
    logic [1:0] m;
    logic [31:0] a, b;

    rst_n = 1'b0; valid = 1'b0; res_ready = 1'b0;
    mode = 2'b00; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_product", product, 64'd0);
    rst_n = 1'b1;

    // Directed values.
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
    chk("uu_ones", p, 64'hFFFF_FFFE_0000_0001);
    chk("latency", 64'(lat), 64'(ITER));
    finish_op();
    chk("idle_after_hs", 64'(in_ready), 64'd1);
    chk("prod_kept_idle", product, 64'hFFFF_FFFE_0000_0001);

    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat); finish_op();
    chk("ss_m1m1", p, 64'h0000_0000_0000_0001);
    start_op(2'b01, 32'h8000_0000, 32'h8000_0000, p, lat); finish_op();
    chk("ss_minmin", p, 64'h4000_0000_0000_0000);
    start_op(2'b01, 32'h8000_0000, 32'h7FFF_FFFF, p, lat); finish_op();
    chk("ss_minmax", p, 64'hC000_0000_8000_0000);
    start_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat); finish_op();
    chk("su_ones", p, 64'hFFFF_FFFF_0000_0001);
    start_op(2'b11, 32'd3, 32'd5, p, lat); finish_op();
    chk("rsv_3x5", p, 64'd15);

    // Backpressure: hold DONE with new requests offered.
    start_op(2'b01, 32'd12345, 32'hFFFF_FFF0, p, lat);
    hold = ref_mul(2'b01, 32'd12345, 32'hFFFF_FFF0);
    chk("bp_value", p, hold);
    valid = 1'b1; mode = 2'b00; multiplicand = 32'd9; multiplier = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_prod_stable", product, hold);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_res_valid", 64'(res_valid), 64'd1);
    end
    valid = 1'b0;
    finish_op();
    chk("bp_release_idle", 64'(in_ready), 64'd1);
    chk("bp_release_rv", 64'(res_valid), 64'd0);

    // Reset mid-CALC at iteration 5.
    mode = 2'b00; multiplicand = 32'hDEAD_BEEF; multiplier = 32'h1234_5678; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_product", product, 64'd0);
    start_op(2'b00, 32'd7, 32'd6, p, lat); finish_op();
    chk("after_rst_7x6", p, 64'd42);
    chk("after_rst_lat", 64'(lat), 64'(ITER));

    // Random regression across all modes and corner values.
    for (int i = 0; i < 2000; i++) begin
      m = 2'($urandom_range(0, 3));
      a = pick_val();
      b = pick_val();
      start_op(m, a, b, p, lat);
      chk("rand", p, ref_mul(m, a, b));
      finish_op();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
